// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the core's load/store
// port (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory with a fixed number of wait
// states between request acceptance and response.
// Optional feature macro: DMEM_ADDR_CHECK_EN (misaligned / out-of-range
// addresses return resp_err=1 and never write). Without it, addresses wrap.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    // Counter reload: WAIT_CYCLES-1, unused (held at 0) when there are no wait states.
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            err_q, err_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic [31:0]     mem_q [DEPTH_WORDS];

    // Commit strobe and the request fields it acts on.
    logic            commit_s;
    logic            c_we_s;
    logic [AW-1:0]   c_idx_s;
    logic [31:0]     c_wdata_s;
    logic [3:0]      c_be_s;
    logic            c_err_s;
    logic            req_err_s;

`ifdef DMEM_ADDR_CHECK_EN
    function automatic logic addr_err_f(input logic [31:0] addr);
        addr_err_f = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
    endfunction

    assign req_err_s = addr_err_f(bus.req_addr);
`else
    // Byte-offset and upper address bits are deliberately ignored (wrap-around).
    logic unused_addr_s;
    assign unused_addr_s = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
    assign req_err_s     = 1'b0;
`endif

    // Next-state, request latching, commit selection and output next values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        err_d     = err_q;
        commit_s  = 1'b0;
        c_we_s    = we_q;
        c_idx_s   = idx_q;
        c_wdata_s = wdata_q;
        c_be_s    = be_q;
        c_err_s   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    idx_d   = bus.req_addr[AW+1:2];
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    err_d   = req_err_s;
                    cnt_d   = CNT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the accept edge is also the commit edge.
                        state_d   = ST_RESP;
                        commit_s  = 1'b1;
                        c_we_s    = bus.req_we;
                        c_idx_s   = bus.req_addr[AW+1:2];
                        c_wdata_s = bus.req_wdata;
                        c_be_s    = bus.req_be;
                        c_err_s   = req_err_s;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (commit_s) begin
            resp_err_d = c_err_s;
            if (!c_we_s && !c_err_s) begin
                resp_rdata_d = mem_q[c_idx_s];
            end else begin
                resp_rdata_d = 32'd0;
            end
        end else begin
            resp_rdata_d = resp_rdata_q;
        end
    end

    // State, latched request and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Byte-masked write on the commit edge; storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && commit_s && c_we_s && !c_err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be_s[i]) begin
                    mem_q[c_idx_s][8*i +: 8] <= c_wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (2 wait states and 0 wait states) checked
// every cycle against a transaction-level model, plus literal expectations.
module tb_dmem_responder;
    logic clk;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   cmp_en = 1'b0;

    logic        rst [2];
    logic        v [2];
    logic        we [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    logic        rr [2];
    logic        o_ready [2];
    logic        o_valid [2];
    logic [31:0] o_rdata [2];
    logic        o_err [2];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    assign bus0.req_valid = v[0];  assign bus1.req_valid = v[1];
    assign bus0.req_we    = we[0]; assign bus1.req_we    = we[1];
    assign bus0.req_addr  = ad[0]; assign bus1.req_addr  = ad[1];
    assign bus0.req_wdata = wd[0]; assign bus1.req_wdata = wd[1];
    assign bus0.req_be    = be[0]; assign bus1.req_be    = be[1];
    assign bus0.resp_ready = rr[0]; assign bus1.resp_ready = rr[1];
    assign o_ready[0] = bus0.req_ready;  assign o_ready[1] = bus1.req_ready;
    assign o_valid[0] = bus0.resp_valid; assign o_valid[1] = bus1.resp_valid;
    assign o_rdata[0] = bus0.resp_rdata; assign o_rdata[1] = bus1.resp_rdata;
    assign o_err[0]   = bus0.resp_err;   assign o_err[1]   = bus1.resp_err;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut0 (.clk(clk), .reset(rst[0]), .bus(bus0));
    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut1 (.clk(clk), .reset(rst[1]), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- transaction-level model ----------------
    logic [31:0] mm [2][64];
    bit          pend [2];
    int          age [2];      // edges since accept, accept edge counts as 1
    bit          m_we [2];
    int          m_idx [2];
    logic [31:0] m_wd [2];
    logic [3:0]  m_be [2];
    bit          m_err [2];
    bit          ev [2];
    logic [31:0] erd [2];
    bit          eerr [2];

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
        return ((a % 4) != 0) || (a >= 32'd256);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_commit(input int k);
        ev[k]   = 1'b1;
        eerr[k] = m_err[k];
        if (m_err[k]) begin
            erd[k] = 32'd0;
        end else if (m_we[k]) begin
            for (int b = 0; b < 4; b++)
                if (m_be[k][b]) mm[k][m_idx[k]][8*b +: 8] = m_wd[k][8*b +: 8];
            erd[k] = 32'd0;
        end else begin
            erd[k] = mm[k][m_idx[k]];
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; ev[k] = 0; erd[k] = 32'd0; eerr[k] = 0; age[k] = 0;
            for (int i = 0; i < 64; i++) mm[k][i] = 'x;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst[k]) begin
                    pend[k] = 0; ev[k] = 0; erd[k] = 32'd0; eerr[k] = 0;
                end else if (!pend[k]) begin
                    if (v[k]) begin
                        pend[k]  = 1;
                        age[k]   = 1;
                        m_we[k]  = we[k];
                        m_idx[k] = int'((ad[k] / 4) % 64);
                        m_wd[k]  = wd[k];
                        m_be[k]  = be[k];
                        m_err[k] = addr_bad(ad[k]);
                        if (age[k] == wait_of(k) + 1) model_commit(k);
                    end
                end else if (age[k] >= wait_of(k) + 1) begin
                    if (rr[k]) begin
                        pend[k] = 0;
                        ev[k]   = 0;
                    end
                end else begin
                    age[k]++;
                    if (age[k] == wait_of(k) + 1) model_commit(k);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("req_ready[%0d]", k), {31'd0, o_ready[k]}, {31'd0, !pend[k]});
                chk($sformatf("resp_valid[%0d]", k), {31'd0, o_valid[k]}, {31'd0, ev[k]});
                if (ev[k]) begin
                    chk($sformatf("resp_rdata[%0d]", k), o_rdata[k], erd[k]);
                    chk($sformatf("resp_err[%0d]", k), {31'd0, o_err[k]}, {31'd0, eerr[k]});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] rd, output logic e,
                          output int lat, output int acc);
        int budget;
        budget = 0;
        we[k] = w; ad[k] = a; wd[k] = d; be[k] = b; v[k] = 1'b1;
        while (!o_ready[k] && budget < 20) begin
            @(posedge clk); #1; budget++;
        end
        chk("accept_bound", {31'd0, o_ready[k]}, 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        // Garbage on the inputs after acceptance must be ignored.
        v[k] = 1'b0; we[k] = ~w; ad[k] = 32'hFFFF_FFFC; wd[k] = ~d; be[k] = 4'hF;
        lat = 1;
        while (!o_valid[k] && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("resp_bound", {31'd0, o_valid[k]}, 32'd1);
        rd = o_rdata[k];
        e  = o_err[k];
        @(posedge clk); #1;
    endtask

    task automatic req_rst(input int k, input logic [31:0] a, input logic [31:0] d, input int n);
        rr[k] = 1'b0;
        we[k] = 1'b1; ad[k] = a; wd[k] = d; be[k] = 4'hF; v[k] = 1'b1;
        @(posedge clk); #1;
        v[k] = 1'b0;
        repeat (n - 1) begin
            @(posedge clk); #1;
        end
        rst[k] = 1'b1;
        @(posedge clk); #1;
        rst[k] = 1'b0;
        rr[k] = 1'b1;
        chk($sformatf("rst%0d_ready", n), {31'd0, o_ready[k]}, 32'd1);
        chk($sformatf("rst%0d_valid", n), {31'd0, o_valid[k]}, 32'd0);
        chk($sformatf("rst%0d_rdata", n), o_rdata[k], 32'd0);
        chk($sformatf("rst%0d_err", n), {31'd0, o_err[k]}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, acc, acc_prev;
        int          budget;
        logic [31:0] snap;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; v[k] = 1'b0; we[k] = 1'b0; ad[k] = 32'd0;
            wd[k] = 32'd0; be[k] = 4'd0; rr[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        cmp_en = 1'b1;
        chk("reset_ready", {31'd0, o_ready[0]}, 32'd1);
        chk("reset_valid", {31'd0, o_valid[0]}, 32'd0);
        chk("reset_rdata", o_rdata[0], 32'd0);
        chk("reset_err", {31'd0, o_err[0]}, 32'd0);

        // Write then read with 2 wait states.
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat, acc);
        chk("wr_lat", lat, 32'd3);
        chk("wr_rdata", rd, 32'd0);
        do_req(0, 1'b0, 32'h10, 32'd0, 4'h0, rd, e, lat, acc);
        chk("rd_lat", lat, 32'd3);
        chk("rd_0x10", rd, 32'hDEADBEEF);
        chk("idle_after_hs", {31'd0, o_ready[0]}, 32'd1);

        // Byte enables, including the no-op be=0000 write.
        do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, e, lat, acc);
        do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e, lat, acc);
        do_req(0, 1'b0, 32'h20, 32'd0, 4'h0, rd, e, lat, acc);
        chk("be_0101", rd, 32'h11BB33DD);
        do_req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, e, lat, acc);
        do_req(0, 1'b0, 32'h20, 32'd0, 4'h0, rd, e, lat, acc);
        chk("be_0000", rd, 32'h11BB33DD);

        // Backpressure: hold RESP for 5 cycles.
        rr[0] = 1'b0;
        we[0] = 1'b0; ad[0] = 32'h10; v[0] = 1'b1;
        @(posedge clk); #1;
        v[0] = 1'b0;
        budget = 0;
        while (!o_valid[0] && budget < 20) begin
            @(posedge clk); #1; budget++;
        end
        chk("bp_valid_bound", {31'd0, o_valid[0]}, 32'd1);
        snap = o_rdata[0];
        chk("bp_rdata", snap, 32'hDEADBEEF);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", {31'd0, o_valid[0]}, 32'd1);
            chk("bp_hold_rdata", o_rdata[0], 32'hDEADBEEF);
            chk("bp_hold_ready", {31'd0, o_ready[0]}, 32'd0);
        end
        rr[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", {31'd0, o_ready[0]}, 32'd1);
        chk("bp_release_valid", {31'd0, o_valid[0]}, 32'd0);

        // Reset in WAIT (cycle 1), on the commit edge (cycle 2), and in RESP (cycle 3).
        do_req(0, 1'b1, 32'h30, 32'hCAFE0001, 4'hF, rd, e, lat, acc);
        req_rst(0, 32'h30, 32'h12345678, 1);
        do_req(0, 1'b0, 32'h30, 32'd0, 4'h0, rd, e, lat, acc);
        chk("rst_wait_old", rd, 32'hCAFE0001);
        req_rst(0, 32'h30, 32'h0BADF00D, 2);
        do_req(0, 1'b0, 32'h30, 32'd0, 4'h0, rd, e, lat, acc);
        chk("rst_commit_edge_old", rd, 32'hCAFE0001);
        req_rst(0, 32'h30, 32'h5555AAAA, 3);
        do_req(0, 1'b0, 32'h30, 32'd0, 4'h0, rd, e, lat, acc);
        chk("rst_resp_kept", rd, 32'h5555AAAA);

        // Address checking / aliasing.
        do_req(0, 1'b1, 32'h0, 32'h0000A5A5, 4'hF, rd, e, lat, acc);
        do_req(0, 1'b0, 32'h102, 32'd0, 4'h0, rd, e, lat, acc);
`ifdef DMEM_ADDR_CHECK_EN
        chk("misalign_err", {31'd0, e}, 32'd1);
        chk("misalign_rdata", rd, 32'd0);
`else
        chk("misalign_err", {31'd0, e}, 32'd0);
        chk("misalign_alias", rd, 32'h0000A5A5);
`endif
        do_req(0, 1'b1, 32'h400, 32'h77777777, 4'hF, rd, e, lat, acc);
        chk("oor_lat", lat, 32'd3);
        do_req(0, 1'b0, 32'h0, 32'd0, 4'h0, rd, e, lat, acc);
`ifdef DMEM_ADDR_CHECK_EN
        chk("oor_mem_unchanged", rd, 32'h0000A5A5);
`else
        chk("oor_alias", rd, 32'h77777777);
`endif

        // Zero wait states: latency 1 and one accept every 2 cycles.
        do_req(1, 1'b1, 32'h0, 32'h00000101, 4'hF, rd, e, lat, acc);
        chk("w0_lat", lat, 32'd1);
        do_req(1, 1'b1, 32'h4, 32'h00000202, 4'hF, rd, e, lat, acc);
        do_req(1, 1'b1, 32'h8, 32'h00000303, 4'hF, rd, e, lat, acc);
        do_req(1, 1'b0, 32'h0, 32'd0, 4'h0, rd, e, lat, acc);
        chk("w0_rd0", rd, 32'h00000101);
        acc_prev = acc;
        do_req(1, 1'b0, 32'h4, 32'd0, 4'h0, rd, e, lat, acc);
        chk("w0_rd4", rd, 32'h00000202);
        chk("w0_period_a", acc - acc_prev, 32'd2);
        acc_prev = acc;
        do_req(1, 1'b0, 32'h8, 32'd0, 4'h0, rd, e, lat, acc);
        chk("w0_rd8", rd, 32'h00000303);
        chk("w0_period_b", acc - acc_prev, 32'd2);
        chk("w0_rd_lat", lat, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
